// File: rtl/acc_seq_ctrl.sv
// Control sequencer for the hash/crypto accelerator: IDLE -> WRITE -> WAIT_HASH -> READ -> DONE.
// Define ACC_SEQ_TIMEOUT_EN to bound the time spent in WAIT_HASH by TIMEOUT_CYCLES.
module acc_seq_ctrl #(
  parameter int DATA_W         = 32,
  parameter int MAX_WORDS      = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CNT_W         = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [CNT_W-1:0]  cfg_n_in_i,
  input  logic [CNT_W-1:0]  cfg_n_out_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_valid_o,
  input  logic              core_ready_i,
  output logic              core_start_o,
  output logic              core_abort_o,
  input  logic              core_done_i,
  input  logic [DATA_W-1:0] core_res_i,
  input  logic              core_res_valid_i,
  output logic              core_res_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [3:0]        status_o,
  output logic [3:0]        error_o,
  output logic              busy_o,
  output logic              irq_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] ERR_OKAY    = 4'h0;
  localparam logic [3:0] ERR_INVALID = 4'h1;
  localparam logic [3:0] ERR_OTHERS  = 4'h2;

  state_t           state;
  logic [CNT_W-1:0] n_in_q;
  logic [CNT_W-1:0] n_out_q;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] in_cnt_nxt;
  logic [CNT_W-1:0] out_cnt_nxt;
  logic             cfg_ok;
  logic             in_hs;
  logic             out_hs;

  // Valid/ready: a word moves only in a cycle where valid and ready are both high;
  // the sequencer never buffers, it just gates the two streams by state.
  assign core_data_o      = in_data_i;
  assign core_valid_o     = in_valid_i && (state == S_WRITE);
  assign in_ready_o       = core_ready_i && (state == S_WRITE);
  assign out_data_o       = core_res_i;
  assign out_valid_o      = core_res_valid_i && (state == S_READ);
  assign core_res_ready_o = out_ready_i && (state == S_READ);

  assign in_hs  = in_valid_i && in_ready_o;
  assign out_hs = out_valid_o && core_res_ready_o;

  assign in_cnt_nxt  = in_cnt + CNT_W'(1);
  assign out_cnt_nxt = out_cnt + CNT_W'(1);

  assign cfg_ok = (cfg_n_in_i  != '0) && (cfg_n_in_i  <= CNT_W'(MAX_WORDS)) &&
                  (cfg_n_out_i != '0) && (cfg_n_out_i <= CNT_W'(MAX_WORDS));

  assign status_o = {1'b0, state};
  assign busy_o   = (state == S_WRITE) || (state == S_WAIT) || (state == S_READ);
  assign irq_o    = (state == S_DONE);

`ifdef ACC_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      error_o      <= ERR_OKAY;
      n_in_q       <= '0;
      n_out_q      <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      core_start_o <= 1'b0;
      core_abort_o <= 1'b0;
`ifdef ACC_SEQ_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      core_start_o <= 1'b0;
      core_abort_o <= 1'b0;
      // Abort beats any handshake in the same cycle, so that word is never counted.
      if (busy_o && clear_i) begin
        state        <= S_DONE;
        error_o      <= ERR_OTHERS;
        core_abort_o <= 1'b1;
        in_cnt       <= '0;
        out_cnt      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !clear_i) begin
              if (cfg_ok) begin
                n_in_q       <= cfg_n_in_i;
                n_out_q      <= cfg_n_out_i;
                in_cnt       <= '0;
                out_cnt      <= '0;
                error_o      <= ERR_OKAY;
                core_start_o <= 1'b1;
                state        <= S_WRITE;
              end else begin
                error_o <= ERR_INVALID;
                state   <= S_DONE;
              end
            end
          end
          S_WRITE: begin
            if (in_hs) begin
              in_cnt <= in_cnt_nxt;
              if (in_cnt_nxt == n_in_q) begin
                state <= S_WAIT;
`ifdef ACC_SEQ_TIMEOUT_EN
                wait_cnt <= '0;
`endif
              end
            end
          end
          S_WAIT: begin
            if (core_done_i) begin
              state <= S_READ;
`ifdef ACC_SEQ_TIMEOUT_EN
            end else if (wait_cnt == TO_LAST) begin
              state        <= S_DONE;
              error_o      <= ERR_OTHERS;
              core_abort_o <= 1'b1;
              in_cnt       <= '0;
              out_cnt      <= '0;
            end else begin
              wait_cnt <= wait_cnt + TO_W'(1);
`endif
            end
          end
          S_READ: begin
            if (out_hs) begin
              out_cnt <= out_cnt_nxt;
              if (out_cnt_nxt == n_out_q) state <= S_DONE;
            end
          end
          S_DONE: begin
            if (clear_i) begin
              state   <= S_IDLE;
              error_o <= ERR_OKAY;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed and randomized bench for acc_seq_ctrl, checked against a transaction-level model.
// Timeout expectations follow the ACC_SEQ_TIMEOUT_EN build.
module tb_acc_seq_ctrl;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;
  localparam int TO_CYC = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              clear_i = 1'b0;
  logic [CNT_W-1:0]  cfg_n_in_i = '0;
  logic [CNT_W-1:0]  cfg_n_out_i = '0;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DATA_W-1:0] core_data_o;
  logic              core_valid_o;
  logic              core_ready_i = 1'b0;
  logic              core_start_o;
  logic              core_abort_o;
  logic              core_done_i = 1'b0;
  logic [DATA_W-1:0] core_res_i = '0;
  logic              core_res_valid_i = 1'b0;
  logic              core_res_ready_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [3:0]        status_o;
  logic [3:0]        error_o;
  logic              busy_o;
  logic              irq_o;

  acc_seq_ctrl #(.DATA_W(DATA_W), .MAX_WORDS(16), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
    .cfg_n_in_i(cfg_n_in_i), .cfg_n_out_i(cfg_n_out_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .core_data_o(core_data_o), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_start_o(core_start_o), .core_abort_o(core_abort_o), .core_done_i(core_done_i),
    .core_res_i(core_res_i), .core_res_valid_i(core_res_valid_i),
    .core_res_ready_o(core_res_ready_o), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .status_o(status_o),
    .error_o(error_o), .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_start  = 0;
  int n_abort  = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Pulse counters: every cycle a pulse is high is counted at the closing edge.
  always @(posedge clk) begin
    if (core_start_o) n_start++;
    if (core_abort_o) n_abort++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int ni, input int no);
    cfg_n_in_i  = CNT_W'(ni);
    cfg_n_out_i = CNT_W'(no);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    cfg_n_in_i  = CNT_W'($urandom);
    cfg_n_out_i = CNT_W'($urandom);
    #1;
    check("start_status", status_o, 32'h1);
    check("start_pulse", core_start_o, 32'h1);
    check("start_busy", busy_o, 32'h1);
    check("start_error", error_o, 32'h0);
  endtask

  task automatic do_write(input int n);
    int sent = 0;
    int guard = 0;
    logic [31:0] e;
    while (sent < n && guard < 400) begin
      in_valid_i   = 1'($urandom_range(0, 1));
      core_ready_i = 1'($urandom_range(0, 1));
      in_data_i    = $urandom;
      #1;
      check("write_status", status_o, 32'h1);
      check("core_valid", core_valid_o, in_valid_i);
      check("in_ready", in_ready_o, core_ready_i);
      if (guard > 0) check("start_once", core_start_o, 32'h0);
      if (in_valid_i && core_ready_i) begin
        exp_q.push_back(in_data_i);
        sent++;
      end
      if (core_valid_o && core_ready_i) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        check("core_data", core_data_o, e);
      end
      cyc();
      guard++;
    end
    check("write_count", sent, n);
    in_valid_i = 1'b1;
    core_ready_i = 1'b1;
    #1;
    check("wait_status", status_o, 32'h2);
    check("wait_in_ready", in_ready_o, 32'h0);
    check("wait_core_valid", core_valid_o, 32'h0);
    in_valid_i = 1'b0;
    core_ready_i = 1'b0;
  endtask

  task automatic do_wait(input int d);
    repeat (d) begin
      core_done_i = 1'b0;
      cyc();
      check("wait_hold", status_o, 32'h2);
    end
    core_done_i = 1'b1;
    cyc();
    core_done_i = 1'b0;
    #1;
    check("read_status", status_o, 32'h3);
  endtask

  task automatic do_read(input int n);
    int sent = 0;
    int guard = 0;
    logic [31:0] e;
    while (sent < n && guard < 400) begin
      core_res_valid_i = 1'($urandom_range(0, 1));
      out_ready_i      = 1'($urandom_range(0, 1));
      core_res_i       = $urandom;
      #1;
      check("read_status", status_o, 32'h3);
      check("out_valid", out_valid_o, core_res_valid_i);
      check("res_ready", core_res_ready_o, out_ready_i);
      if (core_res_valid_i && out_ready_i) begin
        exp_q.push_back(core_res_i);
        sent++;
      end
      if (out_valid_o && out_ready_i) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        check("out_data", out_data_o, e);
      end
      cyc();
      guard++;
    end
    check("read_count", sent, n);
    core_res_valid_i = 1'b0;
    out_ready_i = 1'b0;
  endtask

  task automatic clear_to_idle();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    #1;
    check("idle_status", status_o, 32'h0);
    check("idle_irq", irq_o, 32'h0);
    check("idle_error", error_o, 32'h0);
  endtask

  task automatic run_normal(input int ni, input int no, input int d);
    int s0 = n_start;
    int a0 = n_abort;
    do_start(ni, no);
    do_write(ni);
    do_wait(d);
    do_read(no);
    core_res_valid_i = 1'b1;
    #1;
    check("done_status", status_o, 32'h4);
    check("done_irq", irq_o, 32'h1);
    check("done_error", error_o, 32'h0);
    check("done_busy", busy_o, 32'h0);
    check("done_out_valid", out_valid_o, 32'h0);
    core_res_valid_i = 1'b0;
    start_i = 1'b1;
    core_done_i = 1'b1;
    cyc();
    start_i = 1'b0;
    core_done_i = 1'b0;
    check("done_ignores_start", status_o, 32'h4);
    check("start_pulses", n_start - s0, 32'h1);
    check("no_abort", n_abort - a0, 32'h0);
    clear_to_idle();
  endtask

  initial begin
    int s0;
    int a0;
    int k;
    int sent;
    logic [31:0] words [3];
    int bad_in [4];
    int bad_out [4];
    words = '{32'hDEADBEEF, 32'h1, 32'h2};
    bad_in  = '{0, 3, 17, 5};
    bad_out = '{2, 17, 1, 0};

    // Reset state, with every stream input high to prove the gating.
    in_valid_i = 1'b1; core_ready_i = 1'b1; core_res_valid_i = 1'b1; out_ready_i = 1'b1;
    #12;
    check("rst_status", status_o, 32'h0);
    check("rst_error", error_o, 32'h0);
    check("rst_irq", irq_o, 32'h0);
    check("rst_busy", busy_o, 32'h0);
    check("rst_core_valid", core_valid_o, 32'h0);
    check("rst_in_ready", in_ready_o, 32'h0);
    check("rst_out_valid", out_valid_o, 32'h0);
    check("rst_res_ready", core_res_ready_o, 32'h0);
    check("rst_pulses", {core_start_o, core_abort_o}, 32'h0);
    in_valid_i = 1'b0; core_ready_i = 1'b0; core_res_valid_i = 1'b0; out_ready_i = 1'b0;
    rst_n = 1'b1;
    cyc();

    // start together with clear is a no-op; core_done in IDLE is ignored.
    s0 = n_start;
    cfg_n_in_i = 5'd2; cfg_n_out_i = 5'd2;
    start_i = 1'b1; clear_i = 1'b1; core_done_i = 1'b1;
    cyc();
    start_i = 1'b0; clear_i = 1'b0; core_done_i = 1'b0;
    cyc();
    check("start_clear_noop", status_o, 32'h0);
    check("start_clear_no_pulse", n_start - s0, 32'h0);

    run_normal(4, 2, 3);

    // Illegal counts go straight to DONE with INVALID_CFG.
    for (int i = 0; i < 4; i++) begin
      s0 = n_start;
      cfg_n_in_i = CNT_W'(bad_in[i]);
      cfg_n_out_i = CNT_W'(bad_out[i]);
      start_i = 1'b1;
      core_ready_i = 1'b1;
      cyc();
      start_i = 1'b0;
      #1;
      check("bad_cfg_status", status_o, 32'h4);
      check("bad_cfg_error", error_o, 32'h1);
      check("bad_cfg_in_ready", in_ready_o, 32'h0);
      check("bad_cfg_irq", irq_o, 32'h1);
      cyc();
      check("bad_cfg_no_start", n_start - s0, 32'h0);
      core_ready_i = 1'b0;
      clear_to_idle();
    end

    // Backpressure: ready toggles, valid held, fixed data words.
    do_start(3, 1);
    in_valid_i = 1'b1;
    sent = 0;
    k = 0;
    while (sent < 3 && k < 20) begin
      core_ready_i = 1'(k % 2);
      core_done_i = (k < 2);
      in_data_i = words[sent];
      #1;
      check("bp_status", status_o, 32'h1);
      if (core_ready_i) begin
        check("bp_data", core_data_o, words[sent]);
        check("bp_valid", core_valid_o, 32'h1);
        sent++;
      end
      cyc();
      k++;
    end
    core_done_i = 1'b0;
    check("bp_cycles", k, 32'd6);
    in_valid_i = 1'b1; core_ready_i = 1'b1;
    #1;
    check("bp_wait", status_o, 32'h2);
    check("bp_in_ready_low", in_ready_o, 32'h0);
    in_valid_i = 1'b0; core_ready_i = 1'b0;
    do_wait(0);
    do_read(1);
    #1;
    check("bp_done", status_o, 32'h4);
    clear_to_idle();

    repeat (6) run_normal($urandom_range(1, 16), $urandom_range(1, 16), $urandom_range(0, 5));

    // Abort in READ after 1 of 2 words, clear coinciding with a handshake.
    a0 = n_abort;
    do_start(1, 2);
    do_write(1);
    do_wait(0);
    do_read(1);
    core_res_valid_i = 1'b1; out_ready_i = 1'b1; clear_i = 1'b1;
    #1;
    check("abort_hs_present", out_valid_o, 32'h1);
    cyc();
    clear_i = 1'b0; core_res_valid_i = 1'b0; out_ready_i = 1'b0;
    #1;
    check("abort_read_status", status_o, 32'h4);
    check("abort_read_error", error_o, 32'h2);
    check("abort_read_pulse", core_abort_o, 32'h1);
    cyc();
    check("abort_pulse_end", core_abort_o, 32'h0);
    check("abort_read_count", n_abort - a0, 32'h1);
    clear_to_idle();

    // Abort in WRITE with a handshake in the same cycle.
    a0 = n_abort;
    do_start(4, 4);
    in_valid_i = 1'b1; core_ready_i = 1'b1; clear_i = 1'b1;
    cyc();
    in_valid_i = 1'b0; core_ready_i = 1'b0; clear_i = 1'b0;
    check("abort_write_status", status_o, 32'h4);
    check("abort_write_error", error_o, 32'h2);
    cyc();
    check("abort_write_count", n_abort - a0, 32'h1);
    clear_to_idle();

    // WAIT_HASH with core_done never raised.
    a0 = n_abort;
    do_start(1, 1);
    do_write(1);
`ifdef ACC_SEQ_TIMEOUT_EN
    k = 0;
    while (status_o == 4'h2 && k < 50) begin
      cyc();
      k++;
    end
    check("timeout_cycles", k, TO_CYC);
    check("timeout_status", status_o, 32'h4);
    check("timeout_error", error_o, 32'h2);
    check("timeout_abort", core_abort_o, 32'h1);
`else
    repeat (100) cyc();
    check("no_timeout_status", status_o, 32'h2);
    check("no_timeout_abort", n_abort - a0, 32'h0);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    check("wait_abort_error", error_o, 32'h2);
`endif
    cyc();
    clear_to_idle();

    // Asynchronous reset during the first WRITE cycle.
    a0 = n_abort;
    do_start(5, 1);
    in_valid_i = 1'b1; core_ready_i = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_status", status_o, 32'h0);
    check("arst_in_ready", in_ready_o, 32'h0);
    check("arst_core_valid", core_valid_o, 32'h0);
    check("arst_start", core_start_o, 32'h0);
    check("arst_busy", busy_o, 32'h0);
    check("arst_error", error_o, 32'h0);
    cyc();
    check("arst_no_abort", n_abort - a0, 32'h0);
    in_valid_i = 1'b0; core_ready_i = 1'b0;
    rst_n = 1'b1;
    cyc();
    run_normal(2, 3, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
Parametrised control sequencer for the hash/crypto accelerator. It runs the IDLE→WRITE→WAIT_HASH→READ→DONE flow with configurable input and output word counts, validates the configuration, supports abort, and reports 4-bit status and error codes to the APB register file. It sits between the register/stream interface and the accelerator core. It replaces the fixed single-block flow with a multi-word flow that supports abort and timeout.

Parameters:
DATA_W, 32, width of data words in both directions
MAX_WORDS, 16, largest legal value of cfg_n_in_i / cfg_n_out_i
CNT_W, $clog2(MAX_WORDS+1), word-counter and config-field width (derived, not overridden)
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT_HASH (only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  single-cycle start request
clear_i  in  1  abort when busy; acknowledge/return to IDLE when in DONE
cfg_n_in_i  in  CNT_W  number of input words
cfg_n_out_i  in  CNT_W  number of output words
in_data_i  in  DATA_W  host input word
in_valid_i  in  1  host input valid
in_ready_o  out  1  host input ready
core_data_o  out  DATA_W  word forwarded to the core
core_valid_o  out  1  core input valid
core_ready_i  in  1  core input ready
core_start_o  out  1  one-cycle core start pulse
core_abort_o  out  1  one-cycle core abort pulse
core_done_i  in  1  core finished hashing
core_res_i  in  DATA_W  core result word
core_res_valid_i  in  1  core result valid
core_res_ready_o  out  1  core result ready
out_data_o  out  DATA_W  host output word
out_valid_o  out  1  host output valid
out_ready_i  in  1  host output ready
status_o  out  4  state code: IDLE=0x0, WRITE=0x1, WAIT_HASH=0x2, READ=0x3, DONE=0x4
error_o  out  4  error code: OKAY=0x0, INVALID_CFG=0x1, OTHERS=0x2
busy_o  out  1  high in WRITE, WAIT_HASH and READ
irq_o  out  1  level interrupt, high while in DONE

Behaviour:
- Reset (asynchronous):
  - state IDLE, error OKAY, counters 0, latched cfg 0.
  - All pulse, valid and ready outputs are 0; irq_o=0.
- Data paths are combinational passthroughs gated by state; there is no buffering.
  - core_data_o=in_data_i.
  - core_valid_o=in_valid_i&&WRITE; in_ready_o=core_ready_i&&WRITE.
  - out_data_o=core_res_i.
  - out_valid_o=core_res_valid_i&&READ; core_res_ready_o=out_ready_i&&READ.
- IDLE:
  - start_i && !clear_i with 1≤n_in≤MAX_WORDS and 1≤n_out≤MAX_WORDS: latch both counts, clear error to OKAY, go to WRITE next cycle, and pulse core_start_o for the first WRITE cycle.
  - start_i with an illegal count (0 or >MAX_WORDS): go to DONE with error INVALID_CFG; the core is not started.
  - start_i together with clear_i: clear wins and the cycle is a no-op.
- WRITE:
  - Each in_valid&&in_ready cycle increments in_cnt.
  - The handshake that makes in_cnt equal to n_in moves to WAIT_HASH on the next edge; in_ready_o is low from that cycle on.
- WAIT_HASH:
  - core_done_i=1 moves to READ next cycle.
  - core_done_i is ignored in all other states.
- READ:
  - Each out_valid&&out_ready cycle increments out_cnt.
  - The handshake that makes out_cnt equal to n_out moves to DONE with error unchanged (OKAY).
- DONE:
  - irq_o=1, status_o=0x4, error_o holds its code.
  - start_i is ignored.
  - clear_i moves to IDLE and sets error to OKAY.
- Abort: clear_i in WRITE, WAIT_HASH or READ:
  - next state is DONE with error OTHERS;
  - core_abort_o pulses for one cycle;
  - counters reset;
  - clear_i takes priority over a handshake in the same cycle, and that handshake is not counted.
- Counters reset to 0 on every entry to WRITE.
- Latched cfg is stable for the whole run; changes on the cfg ports mid-run are ignored.
- Reset asserted mid-operation: immediate return to reset values; no abort pulse is generated.

Optional Feature:
ACC_SEQ_TIMEOUT_EN:
- Defined:
  - a wait counter clears on entry to WAIT_HASH and increments each cycle there;
  - if the counter reaches TIMEOUT_CYCLES-1 without core_done_i, next state is DONE with error OTHERS and core_abort_o pulses;
  - core_done_i in the expiry cycle wins and the flow goes to READ.
- Undefined: no counter exists and WAIT_HASH waits indefinitely.

Test Plan:
- Normal run: n_in=4, n_out=2, start; 4 input handshakes then core_done_i, 2 output handshakes.
  → status 1→2→3→4, core_start_o pulses exactly once, irq_o=1, error_o=0x0; clear_i → status 0x0.
- Invalid config: n_in=0 with start, and separately n_out=17 (MAX_WORDS=16).
  → DONE, error_o=0x1, core_start_o never pulses, in_ready_o stays 0.
- Backpressure: core_ready_i toggles every cycle while in_valid_i is held high for n_in=3.
  → exactly 3 words are counted, with data passed unchanged (e.g. 0xDEADBEEF, 0x1, 0x2); then WAIT_HASH.
- Abort in READ after 1 of 2 words, with clear_i and an out handshake in the same cycle.
  → DONE, error_o=0x2, core_abort_o pulses once, the second word is not counted.
- Timeout (macro defined, TIMEOUT_CYCLES=8): core_done_i is never raised.
  → DONE exactly 8 cycles after WAIT_HASH entry, error_o=0x2.
  → With the macro undefined, the block is still in WAIT_HASH after 100 cycles.
- Async reset pulse mid-WRITE.
  → All outputs are at reset values immediately, before the next clock edge; status_o=0x0.
